// File: rtl/ahb_sram_rmw_bridge.sv
// AHB-Lite slave in front of a single-port 32-bit SRAM. Subword writes are done
// as a read-modify-write; misaligned or oversized transfers get a two-cycle ERROR.
module ahb_sram_rmw_bridge #(
  parameter int ADDR_BITS = 15
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   HSEL,
  input  logic [ADDR_BITS+1:0]   HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic [31:0]            HWDATA,
  input  logic                   HREADY,
  output logic                   HREADYOUT,
  output logic [31:0]            HRDATA,
  output logic                   HRESP,
  output logic [ADDR_BITS-1:0]   A,
  output logic [31:0]            D,
  output logic                   BWE_n,
  output logic                   CE_n,
  input  logic [31:0]            Q
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_RD1    = 3'd2;
  localparam logic [2:0] S_RD2    = 3'd3;
  localparam logic [2:0] S_RMW_RD = 3'd4;
  localparam logic [2:0] S_RMW_WR = 3'd5;
  localparam logic [2:0] S_ERR1   = 3'd6;
  localparam logic [2:0] S_ERR2   = 3'd7;

  logic [2:0]           state_reg;
  logic [2:0]           state_next;
  logic [ADDR_BITS+1:0] addr_q;
  logic [1:0]           size_q;
  logic                 write_q;

  logic                 capture;
  logic                 illegal;
  logic [2:0]           decoded_state;
  logic [3:0]           lane_en;
  logic [31:0]          merged;
  logic                 unused_htrans;

  // HTRANS[0] only separates SEQ from NONSEQ, which this slave treats alike.
  assign unused_htrans = HTRANS[0];

  assign capture = HSEL & HTRANS[1] & HREADY;

  assign illegal = (HSIZE > 3'd2)
                 | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                 | ((HSIZE == 3'd1) & HADDR[0]);

  always_comb begin
    decoded_state = S_RMW_RD;
    if (illegal) begin
      decoded_state = S_ERR1;
    end else if (!HWRITE) begin
      decoded_state = S_RD1;
    end else if (HSIZE == 3'd2) begin
      decoded_state = S_WR;
    end
  end

  // Byte lanes written from HWDATA; the rest keep the value just read from Q.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_en[gi] = (size_q == 2'd0) ? (addr_q[1:0] == LANE) :
                           (size_q == 2'd1) ? (addr_q[1] == LANE[1]) : 1'b1;
      assign merged[gi*8 +: 8] = lane_en[gi] ? HWDATA[gi*8 +: 8] : Q[gi*8 +: 8];
    end
  endgenerate

  // Completion states accept the next address phase; wait states just advance.
  always_comb begin
    state_next = state_reg;
    if (HREADYOUT) begin
      state_next = capture ? decoded_state : S_IDLE;
    end else begin
      case (state_reg)
        S_RD1:    state_next = S_RD2;
        S_RMW_RD: state_next = S_RMW_WR;
        S_ERR1:   state_next = S_ERR2;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= S_IDLE;
      addr_q    <= '0;
      size_q    <= 2'd0;
      write_q   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (HREADYOUT && capture) begin
        addr_q  <= HADDR;
        size_q  <= HSIZE[1:0];
        write_q <= HWRITE;
      end
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRDATA    = 32'h0;
    HRESP     = 1'b0;
    A         = addr_q[ADDR_BITS+1:2];
    D         = 32'h0;
    BWE_n     = 1'b1;
    CE_n      = 1'b1;
    case (state_reg)
      S_WR: begin
        CE_n  = 1'b0;
        BWE_n = ~write_q;
        D     = HWDATA;
      end
      S_RD1: begin
        CE_n      = 1'b0;
        HREADYOUT = 1'b0;
      end
      S_RD2: begin
        HRDATA = Q;
      end
      S_RMW_RD: begin
        CE_n      = 1'b0;
        HREADYOUT = 1'b0;
      end
      S_RMW_WR: begin
        CE_n  = 1'b0;
        BWE_n = ~write_q;
        D     = merged;
      end
      S_ERR1: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b0;
        A         = '0;
      end
      S_ERR2: begin
        HRESP = 1'b1;
        A     = '0;
      end
      default: begin
      end
    endcase
    // Reset must block the SRAM even mid-RMW, before the state register clears.
    if (RST) begin
      CE_n  = 1'b1;
      BWE_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_ahb_sram_rmw_bridge.sv
// Directed bench for ahb_sram_rmw_bridge: an AHB master task queues expected
// responses and SRAM writes; a negedge monitor pops and compares them.
module tb_ahb_sram_rmw_bridge;

  localparam int AB = 15;

  logic          CLK = 1'b0;
  logic          RST;
  logic          HSEL;
  logic [AB+1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic          HRESP;
  logic [AB-1:0] A;
  logic [31:0]   D;
  logic          BWE_n;
  logic          CE_n;
  logic [31:0]   Q;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        err;
    logic        rd;
    int          waits;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [AB-1:0] a;
    logic [31:0]   d;
  } wr_t;

  resp_t exp_q[$];
  wr_t   wr_q[$];

  logic [31:0] mem [0:(1<<AB)-1];
  logic [31:0] prev_wdata = 32'h0;

  always #5 CLK = ~CLK;

  assign HREADY = HREADYOUT;

  ahb_sram_rmw_bridge #(.ADDR_BITS(AB)) dut (
    .CLK(CLK), .RST(RST), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP), .A(A), .D(D),
    .BWE_n(BWE_n), .CE_n(CE_n), .Q(Q)
  );

  // SRAM model: registered read, word write.
  initial begin
    for (int i = 0; i < (1<<AB); i++) mem[i] = 32'h0;
    Q = 32'h0;
  end
  always @(posedge CLK) begin
    if (!CE_n) begin
      if (!BWE_n) mem[A] <= D;
      else        Q <= mem[A];
    end
  end

  // Monitor
  logic  in_dp = 1'b0;
  int    waits_seen = 0;
  resp_t cur;

  always @(negedge CLK) begin
    if (RST) begin
      in_dp = 1'b0;
    end else begin
      if (!CE_n && !BWE_n) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL sram_write unexpected: A=%h D=%h, none required", A, D);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          if (A !== w.a || D !== w.d) begin
            errors++;
            $display("FAIL sram_write: A=%h D=%h, required A=%h D=%h", A, D, w.a, w.d);
          end
        end
      end
      if (in_dp) begin
        checks++;
        if (HRESP !== cur.err) begin
          errors++;
          $display("FAIL hresp: got %b, required %b", HRESP, cur.err);
        end
        if (cur.err) begin
          checks++;
          if (CE_n !== 1'b1) begin
            errors++;
            $display("FAIL err_ce_n: got %b, required 1", CE_n);
          end
        end
        if (HREADYOUT) begin
          checks++;
          if (waits_seen != cur.waits) begin
            errors++;
            $display("FAIL wait_states: got %0d, required %0d", waits_seen, cur.waits);
          end
          if (cur.rd) begin
            checks++;
            if (HRDATA !== cur.rdata) begin
              errors++;
              $display("FAIL hrdata: got %h, required %h", HRDATA, cur.rdata);
            end else begin
              $display("read  ok  data=%h waits=%0d", HRDATA, waits_seen);
            end
          end else begin
            $display("xfer  done err=%b waits=%0d", HRESP, waits_seen);
          end
          in_dp = 1'b0;
        end else begin
          waits_seen++;
        end
      end
      if (HREADYOUT && HSEL && HTRANS[1]) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL accept: transfer accepted with no expectation queued (got 0, required 1)");
        end else begin
          cur = exp_q.pop_front();
          in_dp = 1'b1;
          waits_seen = 0;
        end
      end
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (HREADYOUT) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL timeout: HREADYOUT got 0, required 1 within 50 cycles");
    end
  endtask

  task automatic do_xfer(input logic [AB+1:0] addr, input logic [2:0] size,
                         input logic wr, input logic [31:0] wdata,
                         input logic err, input int waits, input logic [31:0] expv);
    resp_t r;
    wr_t   w;
    r.err = err; r.rd = !wr && !err; r.waits = waits; r.rdata = expv;
    exp_q.push_back(r);
    if (wr && !err) begin
      w.a = addr[AB+1:2]; w.d = expv;
      wr_q.push_back(w);
    end
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HSIZE = size; HWRITE = wr;
    HWDATA = prev_wdata;
    wait_ready();
    @(posedge CLK); #1;
    prev_wdata = wdata;
  endtask

  task automatic do_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = prev_wdata;
    wait_ready();
    @(posedge CLK); #1;
    prev_wdata = 32'h0;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd0; HWDATA = 32'h0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_val("rst_ce_n", 32'(CE_n), 32'h1);
    check_val("rst_bwe_n", 32'(BWE_n), 32'h1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check_val("post_rst_hreadyout", 32'(HREADYOUT), 32'h1);
    check_val("post_rst_hresp", 32'(HRESP), 32'h0);
    check_val("post_rst_hrdata", HRDATA, 32'h0);
    check_val("post_rst_a", 32'(A), 32'h0);
    check_val("post_rst_d", D, 32'h0);
    @(posedge CLK); #1;

    // word write, read back, then subword RMW writes
    do_xfer(17'h00010, 3'd2, 1'b1, 32'hDEADBEEF, 1'b0, 0, 32'hDEADBEEF);
    do_idle();
    do_xfer(17'h00010, 3'd2, 1'b0, 32'h0,        1'b0, 1, 32'hDEADBEEF);
    do_xfer(17'h00013, 3'd0, 1'b1, 32'hAA000000, 1'b0, 1, 32'hAAADBEEF);
    do_idle();
    do_xfer(17'h00010, 3'd2, 1'b0, 32'h0,        1'b0, 1, 32'hAAADBEEF);
    do_xfer(17'h00012, 3'd1, 1'b1, 32'h12340000, 1'b0, 1, 32'h1234BEEF);
    do_xfer(17'h00010, 3'd0, 1'b1, 32'h00000077, 1'b0, 1, 32'h1234BE77);
    do_xfer(17'h00010, 3'd2, 1'b0, 32'h0,        1'b0, 1, 32'h1234BE77);

    // illegal transfers, back to back
    do_xfer(17'h00002, 3'd2, 1'b0, 32'h0,        1'b1, 1, 32'h0);
    do_xfer(17'h00000, 3'd3, 1'b0, 32'h0,        1'b1, 1, 32'h0);
    do_xfer(17'h00011, 3'd1, 1'b1, 32'h55555555, 1'b1, 1, 32'h0);
    do_idle();

    // pipelined write then read of the same word, more lane merges
    do_xfer(17'h00020, 3'd2, 1'b1, 32'hCAFEF00D, 1'b0, 0, 32'hCAFEF00D);
    do_xfer(17'h00020, 3'd2, 1'b0, 32'h0,        1'b0, 1, 32'hCAFEF00D);
    do_xfer(17'h00021, 3'd0, 1'b1, 32'h0000AB00, 1'b0, 1, 32'hCAFEAB0D);
    do_xfer(17'h00020, 3'd1, 1'b1, 32'h00005678, 1'b0, 1, 32'hCAFE5678);
    do_xfer(17'h00020, 3'd2, 1'b0, 32'h0,        1'b0, 1, 32'hCAFE5678);
    do_idle();

    // reset during RMW_RD aborts the byte write
    begin
      resp_t r;
      r.err = 1'b0; r.rd = 1'b0; r.waits = 1; r.rdata = 32'h0;
      exp_q.push_back(r);
    end
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 17'h00012; HSIZE = 3'd0; HWRITE = 1'b1;
    HWDATA = 32'h0;
    wait_ready();
    @(posedge CLK); #1;
    RST = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = 32'h00550000;
    @(negedge CLK);
    check_val("rmw_rst_ce_n", 32'(CE_n), 32'h1);
    check_val("rmw_rst_bwe_n", 32'(BWE_n), 32'h1);
    @(posedge CLK); #1;
    RST = 1'b0; HWDATA = 32'h0;
    @(negedge CLK);
    check_val("rmw_post_rst_hreadyout", 32'(HREADYOUT), 32'h1);
    check_val("rmw_post_rst_ce_n", 32'(CE_n), 32'h1);
    check_val("rmw_post_rst_a", 32'(A), 32'h0);
    check_val("rmw_post_rst_d", D, 32'h0);
    @(posedge CLK); #1;
    prev_wdata = 32'h0;
    do_xfer(17'h00010, 3'd2, 1'b0, 32'h0, 1'b0, 1, 32'h1234BE77);
    do_idle();
    do_idle();

    check_val("exp_queue_drained", 32'(exp_q.size()), 32'h0);
    check_val("wr_queue_drained", 32'(wr_q.size()), 32'h0);
    check_val("mem_word_0x20", mem[8], 32'hCAFE5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_sram_rmw_bridge.md
Name: ahb_sram_rmw_bridge

Overview:
AHB-Lite slave that converts core bus transfers into single-port commands for sram_32Kx32_wrapper. It drives A/D/BWE_n/CE_n and consumes Q.
The SRAM has only a word-wide write enable, so byte and halfword writes use an internal read-modify-write sequence. The block also flags unaligned or illegal-size transfers with a two-cycle AHB ERROR response.

Parameters:
ADDR_BITS, 15, SRAM word-address width; HADDR width is ADDR_BITS+2.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous reset, active-high
HSEL  input  1  slave select
HADDR  input  ADDR_BITS+2  byte address
HTRANS  input  2  transfer type; only bit 1 is significant (NONSEQ/SEQ)
HWRITE  input  1  1 = write
HSIZE  input  3  0 = byte, 1 = halfword, 2 = word, others illegal
HWDATA  input  32  write data, valid in the data phase
HREADY  input  1  bus-level ready (address-phase qualifier)
HREADYOUT  output  1  slave ready
HRDATA  output  32  read data
HRESP  output  1  1 = ERROR
A  output  ADDR_BITS  SRAM word address
D  output  32  SRAM write data
BWE_n  output  1  SRAM write enable, active-low
CE_n  output  1  SRAM chip enable, active-low
Q  input  32  SRAM read data, valid the cycle after a read command

Behaviour:
Address capture:
- Capture condition: HSEL & HTRANS[1] & HREADY.
- When it holds, register addr_q, size_q, write_q and select the next state from the decode below.
- When HREADY=1 and the condition is false, next state = IDLE. IDLE/BUSY transfers are ignored.

Decode of a captured transfer:
- Illegal if HSIZE>2, (HSIZE==2 & HADDR[1:0]!=0), or (HSIZE==1 & HADDR[0]!=0) -> ERR1.
- Otherwise: read -> RD1; word write -> WR; byte or halfword write -> RMW_RD.

FSM, one state per data-phase cycle:
- IDLE: HREADYOUT=1; capture allowed.
- WR: CE_n=0, BWE_n=0, D=HWDATA; HREADYOUT=1; capture allowed. Zero wait states.
- RD1: CE_n=0, BWE_n=1; HREADYOUT=0; -> RD2.
- RD2: HRDATA=Q; HREADYOUT=1; capture allowed. Read = 1 wait state.
- RMW_RD: CE_n=0, BWE_n=1; HREADYOUT=0; -> RMW_WR.
- RMW_WR: CE_n=0, BWE_n=0, D=merge(Q, HWDATA); HREADYOUT=1; capture allowed. Subword write = 1 wait state.
- ERR1: CE_n=1, HRESP=1, HREADYOUT=0; -> ERR2.
- ERR2: CE_n=1, HRESP=1, HREADYOUT=1; capture allowed.

Outputs and datapath:
- In every non-error state A = addr_q[ADDR_BITS+1:2].
- merge: byte lane addr_q[1:0] (or halfword lane addr_q[1]) is taken from HWDATA; all other lanes come from Q. HWDATA is held by the master through the wait state.
- Outside WR/RMW_WR: D=0. Outside RD2: HRDATA=0. Outside ERR1/ERR2: HRESP=0.

Back-to-back transfers:
- A new address phase is captured in any completion state, so pipelined transfers have no idle bubble.
- While HREADYOUT=0 no capture occurs; the master holds the next address phase.

Reset:
- While RST=1, CE_n and BWE_n are forced to 1 combinationally, so no SRAM access occurs in the reset cycle.
- At the edge: state=IDLE, addr_q=0, size_q=0, write_q=0.
- Post-reset outputs: HREADYOUT=1, HRESP=0, HRDATA=0, A=0, D=0, CE_n=1, BWE_n=1.
- RST in any state, including mid-RMW, aborts the transfer; no partial write is issued.

Test Plan:
- Word write 0x00010 = 0xDEADBEEF -> one data-phase cycle, HREADYOUT=1, CE_n=0, BWE_n=0, A=0x0004, D=0xDEADBEEF.
- Read 0x00010 after the write -> HREADYOUT 0 then 1; HRDATA=0xDEADBEEF in the second cycle; HRESP=0.
- Byte write 0x00013, HWDATA=0xAA000000 onto 0xDEADBEEF -> RMW_RD (BWE_n=1, HREADYOUT=0) then RMW_WR with D=0xAAADBEEF; a later read returns 0xAAADBEEF.
- Halfword write 0x00012, HWDATA=0x1234_0000 -> D=0x1234BEEF. Byte write 0x00010, HWDATA=0x00000077 -> D=0x1234BE77.
- Word read at 0x00002, and HSIZE=3 at 0x00000 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, CE_n=1 throughout.
- Pipelined write 0x00020 then read 0x00020 -> write completes with zero wait; read returns the new data one cycle later.
- RST asserted during RMW_RD -> CE_n=1 in that cycle, then IDLE, HREADYOUT=1, and the memory word is unchanged.
